// File: rtl/bomb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bomb_pkg
// Purpose  : Shared definitions for the code entry / display stages:
//            verification state encoding, code derivation constants and the
//            code-expansion helpers. The password-display stage calls the
//            same functions, so the displayed and checked codes are identical.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bomb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
        CHECK   = 3'd2,
        SUCCESS = 3'd3,
        FAIL    = 3'd4
    } state_t;

    localparam int CODE_STEP  = 7;
    localparam int CODE_MOD   = 10;
    localparam int MAX_DIGITS = 8;

    // Digit idx of the code generated from a 5-bit seed.
    function automatic logic [3:0] code_digit(input logic [4:0] seed, input int idx);
        int v;
        v = (int'(seed) + CODE_STEP * idx) % CODE_MOD;
        return 4'(v);
    endfunction

    // Full code for the widest configuration, digit 0 in the LSBs.
    function automatic logic [4*MAX_DIGITS-1:0] expand_code(input logic [4:0] seed);
        logic [4*MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            v[4*i +: 4] = code_digit(seed, i);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_entry_buf.sv
`default_nettype none
// ============================================================================
// Module   : code_entry_buf
// Purpose  : Slot register holding the digits of the attempt being typed.
//            A load writes the digit at slot digit_count and advances the
//            count; clear empties the buffer and takes priority over load.
// Ports    : clk, Rst (sync, active-low)
//            clear        - empty the buffer
//            load         - store digit in the next free slot
//            digit        - BCD digit to store
//            entered      - all slots, slot 0 in the LSBs, empty slots 0
//            digit_count  - number of filled slots (0..DIGITS)
// Revision : 1.0 - initial release
// ============================================================================
module code_entry_buf #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic                clear,
    input  logic                load,
    input  logic [3:0]          digit,
    output logic [4*DIGITS-1:0] entered,
    output logic [3:0]          digit_count
);

    logic [3:0] r_count;
    logic       w_store;

    // A full buffer never accepts another digit.
    assign w_store = load && !clear && (r_count < 4'(DIGITS));

    always_ff @(posedge clk) begin
        if (!Rst || clear) begin
            r_count <= 4'd0;
        end else if (w_store) begin
            r_count <= r_count + 4'd1;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_slot
        logic [3:0] r_digit;

        always_ff @(posedge clk) begin
            if (!Rst || clear) begin
                r_digit <= 4'd0;
            end else if (w_store && (r_count == 4'(i))) begin
                r_digit <= digit;
            end
        end

        assign entered[4*i +: 4] = r_digit;
    end

    assign digit_count = r_count;

endmodule
`default_nettype wire

// File: rtl/code_verify.sv
`default_nettype none
// ============================================================================
// Module   : code_verify
// Purpose  : Password entry and verification. Latches the code derived from
//            code_seed when entry starts, collects keypad digits, checks each
//            full attempt and reports sticky fail/success to game control.
//            Optional wrong-attempt penalty pulse: CODE_VERIFY_PENALTY_EN.
// Ports    : clk, Rst (sync, active-low)
//            start_input - entry allowed (level)
//            code_seed   - 5-bit seed, sampled when entry starts
//            key_valid/key_digit - debounced key pulse and BCD digit
//            key_clear   - discard partial entry
//            timeout     - countdown expired
//            fail/success - sticky result flags
//            digit_count/tries_left/entered - progress for the display
//            penalty     - one-cycle pulse per non-final wrong attempt
// Revision : 1.0 - initial release
// ============================================================================
module code_verify
    import bomb_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int MAX_TRIES   = 3,
    parameter int PENALTY_SEC = 2
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic                start_input,
    input  logic [4:0]          code_seed,
    input  logic                key_valid,
    input  logic [3:0]          key_digit,
    input  logic                key_clear,
    input  logic                timeout,
    output logic                fail,
    output logic                success,
    output logic [3:0]          digit_count,
    output logic [2:0]          tries_left,
    output logic [4*DIGITS-1:0] entered,
    output logic                penalty
);

    if ((DIGITS < 1) || (DIGITS > MAX_DIGITS) || (MAX_TRIES < 1) || (MAX_TRIES > 7)
        || (PENALTY_SEC < 0)) begin : g_param_check
        $error("code_verify: parameter out of range");
    end

    state_t              r_state;
    state_t              w_next;
    logic [4*DIGITS-1:0] r_code;
    logic [4*DIGITS-1:0] w_code;
    logic [2:0]          r_tries;
    logic                w_buf_clear;
    logic                w_buf_load;
    logic                w_latch;
    logic                w_dec;
    logic                w_zero;

    for (genvar i = 0; i < DIGITS; i++) begin : g_code
        assign w_code[4*i +: 4] = code_digit(code_seed, i);
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_buf_clear = 1'b0;
        w_buf_load  = 1'b0;
        w_latch     = 1'b0;
        w_dec       = 1'b0;
        w_zero      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_input) begin
                    w_next      = ENTER;
                    w_latch     = 1'b1;
                    w_buf_clear = 1'b1;
                end
            end
            ENTER: begin
                if (timeout) begin
                    w_next = FAIL;
                end else if (!start_input) begin
                    w_next      = IDLE;
                    w_buf_clear = 1'b1;
                end else begin
                    w_buf_clear = key_clear;
                    w_buf_load  = key_valid && (key_digit <= 4'd9);
                    // Move to CHECK on the same edge the last digit lands,
                    // so the CHECK cycle always sees a complete attempt.
                    if (w_buf_load && !key_clear && (digit_count == 4'(DIGITS - 1))) begin
                        w_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (timeout) begin
                    w_next = FAIL;
                end else if (!start_input) begin
                    w_next      = IDLE;
                    w_buf_clear = 1'b1;
                end else if (entered == r_code) begin
                    w_next = SUCCESS;
                end else if (r_tries > 3'd1) begin
                    w_next      = ENTER;
                    w_dec       = 1'b1;
                    w_buf_clear = 1'b1;
                end else begin
                    w_next = FAIL;
                    w_zero = 1'b1;
                end
            end
            SUCCESS: w_next = SUCCESS;
            FAIL:    w_next = FAIL;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            r_tries <= 3'(MAX_TRIES);
            r_code  <= '0;
        end else if (w_latch) begin
            r_tries <= 3'(MAX_TRIES);
            r_code  <= w_code;
        end else if (w_dec) begin
            r_tries <= r_tries - 3'd1;
        end else if (w_zero) begin
            r_tries <= 3'd0;
        end
    end

    code_entry_buf #(
        .DIGITS (DIGITS)
    ) u_entry (
        .clk         (clk),
        .Rst         (Rst),
        .clear       (w_buf_clear),
        .load        (w_buf_load),
        .digit       (key_digit),
        .entered     (entered),
        .digit_count (digit_count)
    );

`ifdef CODE_VERIFY_PENALTY_EN
    logic r_penalty;

    always_ff @(posedge clk) begin
        if (!Rst) begin
            r_penalty <= 1'b0;
        end else begin
            r_penalty <= w_dec;
        end
    end

    assign penalty = r_penalty;
`else
    assign penalty = 1'b0;
`endif

    assign success    = (r_state == SUCCESS);
    assign fail       = (r_state == FAIL);
    assign tries_left = r_tries;

endmodule
`default_nettype wire
